// File: rtl/gf180mcu_extra__dffm_pipe_if.sv
// Handshake, data and scan bundle for the multi-bit pipeline register.
// master: upstream producer / downstream consumer / scan driver side.
// slave:  the pipeline itself.
interface gf180mcu_extra__dffm_pipe_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  logic                       IN_VALID;
  logic                       IN_READY;
  logic [WIDTH-1:0]           D;
  logic                       OUT_VALID;
  logic                       OUT_READY;
  logic [WIDTH-1:0]           Q;
  logic                       SE;
  logic                       SI;
  logic                       SO;
  logic [$clog2(DEPTH+1)-1:0] COUNT;

  modport master (
    output IN_VALID, D, OUT_READY, SE, SI,
    input  IN_READY, OUT_VALID, Q, SO, COUNT
  );

  modport slave (
    input  IN_VALID, D, OUT_READY, SE, SI,
    output IN_READY, OUT_VALID, Q, SO, COUNT
  );
endinterface

// File: rtl/gf180mcu_extra__dffm_pipe.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with a scan chain
// threaded through every data bit and an occupancy count.
//
// Handshake: a word moves across a boundary on a rising edge when the
// sender's valid and the receiver's ready are both 1 in the cycle before
// that edge. Valid never depends on ready. Once OUT_VALID is 1, OUT_VALID and
// Q hold until OUT_READY is seen. IN_READY depends combinationally on
// OUT_READY through the ready chain, so bubbles collapse; this path must be
// covered by the timing constraints.
module gf180mcu_extra__dffm_pipe #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
`ifdef USE_POWER_PINS
  input logic VPW,
  input logic VNW,
  input logic VDD,
  input logic VSS,
`endif
  input logic CLK,
  input logic RST_N,
  gf180mcu_extra__dffm_pipe_if.slave bus
);

  localparam int N  = WIDTH * DEPTH;
  localparam int CW = $clog2(DEPTH + 1);

  // Stage k: valid bit v[k], data d[k]. Stage 0 is the input side.
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;

  logic [DEPTH:0]              r;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][WIDTH-1:0] up_d;
  logic [N-1:0]                chain;
  logic [N-1:0]                chain_next;
  logic [CW-1:0]               count;

  // Ready chain from the output back to the input; each stage also sees
  // what sits immediately upstream of it.
  assign r[DEPTH] = bus.OUT_READY;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign r[g] = ~v[g] | r[g+1];
    if (g == 0) begin : g_first
      assign up_v[g] = bus.IN_VALID;
      assign up_d[g] = bus.D;
    end else begin : g_rest
      assign up_v[g] = v[g-1];
      assign up_d[g] = d[g-1];
    end
  end

  // Flattened data: bit k*WIDTH+b is d[k][b], so a left shift walks the
  // scan order SI -> d[0][0] -> ... -> d[DEPTH-1][WIDTH-1].
  assign chain = d;

  if (N == 1) begin : g_chain_one
    assign chain_next = bus.SI;
  end else begin : g_chain_many
    assign chain_next = {chain[N-2:0], bus.SI};
  end

  // State update: reset first, then scan shift (valid bits frozen), then
  // normal flow; data only loads on a valid upstream word to avoid toggling
  // on bubbles.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= RESET_VAL;
      end
    end else if (bus.SE) begin
      d <= chain_next;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r[k]) begin
          v[k] <= up_v[k];
          if (up_v[k]) begin
            d[k] <= up_d[k];
          end
        end
      end
    end
  end

  // Occupancy is the population count of the valid flops.
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CW'(v[k]);
    end
  end

  assign bus.IN_READY  = r[0] & ~bus.SE;
  assign bus.OUT_VALID = v[DEPTH-1] & ~bus.SE;
  assign bus.Q         = d[DEPTH-1];
  assign bus.SO        = d[DEPTH-1][WIDTH-1];
  assign bus.COUNT     = count;

endmodule

// File: tb/tb_gf180mcu_extra__dffm_pipe.sv
// Directed bench for gf180mcu_extra__dffm_pipe (WIDTH=4, DEPTH=2, RESET_VAL=4'hA).
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit
// later, well away from the next edge.
module tb_gf180mcu_extra__dffm_pipe;

  localparam int               WIDTH     = 4;
  localparam int               DEPTH     = 2;
  localparam logic [WIDTH-1:0] RESET_VAL = 4'hA;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gf180mcu_extra__dffm_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  gf180mcu_extra__dffm_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RESET_VAL)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] dv, input logic ordy);
    bus.IN_VALID  = iv;
    bus.D         = dv;
    bus.OUT_READY = ordy;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [WIDTH-1:0] q,
                            input logic [1:0] cnt);
    check({tag, "_ov"}, 32'(bus.OUT_VALID), 32'(ov));
    check({tag, "_q"}, 32'(bus.Q), 32'(q));
    check({tag, "_cnt"}, 32'(bus.COUNT), 32'(cnt));
  endtask

  logic [7:0] scan_pat;
  logic [7:0] so_orig;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.IN_VALID = 1'b1; bus.D = 4'h3; bus.OUT_READY = 1'b0;
    bus.SE = 1'b0; bus.SI = 1'b0;

    // Reset held for two edges with IN_VALID high.
    step(); step();
    #1;
    expect_out("rst", 1'b0, 4'hA, 2'd0);
    check("rst_so", 32'(bus.SO), 32'd1);
    rst_n = 1'b1;

    // Streaming 1,2,3,4 with OUT_READY high.
    drive(1'b1, 4'h1, 1'b1); check("str0_ir", 32'(bus.IN_READY), 32'd1);
    expect_out("str0", 1'b0, 4'hA, 2'd0); step();
    drive(1'b1, 4'h2, 1'b1); check("str1_ir", 32'(bus.IN_READY), 32'd1);
    expect_out("str1", 1'b0, 4'hA, 2'd1); step();
    drive(1'b1, 4'h3, 1'b1); check("str2_ir", 32'(bus.IN_READY), 32'd1);
    expect_out("str2", 1'b1, 4'h1, 2'd2); step();
    drive(1'b1, 4'h4, 1'b1); check("str3_ir", 32'(bus.IN_READY), 32'd1);
    expect_out("str3", 1'b1, 4'h2, 2'd2); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("str4", 1'b1, 4'h3, 2'd2); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("str5", 1'b1, 4'h4, 2'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("str6", 1'b0, 4'h4, 2'd0);

    // Backpressure: 5 and 6 fill the pipe, 7 waits.
    drive(1'b1, 4'h5, 1'b0); check("bp0_ir", 32'(bus.IN_READY), 32'd1); step();
    drive(1'b1, 4'h6, 1'b0); check("bp1_ir", 32'(bus.IN_READY), 32'd1);
    expect_out("bp1", 1'b0, 4'h4, 2'd1); step();
    drive(1'b1, 4'h7, 1'b0); check("bp2_ir", 32'(bus.IN_READY), 32'd0);
    expect_out("bp2", 1'b1, 4'h5, 2'd2); step();
    drive(1'b1, 4'h7, 1'b0); check("bp3_ir", 32'(bus.IN_READY), 32'd0);
    expect_out("bp3", 1'b1, 4'h5, 2'd2);
    drive(1'b1, 4'h7, 1'b1); check("bp3_ir_comb", 32'(bus.IN_READY), 32'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("bp4", 1'b1, 4'h6, 2'd2); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("bp5", 1'b1, 4'h7, 2'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("bp6", 1'b0, 4'h7, 2'd0);

    // Full with 8,9, then emit 8 and accept 10 on the same edge.
    drive(1'b1, 4'h8, 1'b0); step();
    drive(1'b1, 4'h9, 1'b0); step();
    drive(1'b1, 4'hA, 1'b1); check("fs_ir", 32'(bus.IN_READY), 32'd1);
    expect_out("fs0", 1'b1, 4'h8, 2'd2); step();
    drive(1'b0, 4'h0, 1'b0); expect_out("fs1", 1'b1, 4'h9, 2'd2);

    // Scan: chain holds d0=4'hA, d1=4'h9. SO before shift i is chain bit 7-i.
    scan_pat = 8'b1011_0010;          // shifted MSB first: 1,0,1,1,0,0,1,0
    so_orig  = 8'b1001_1010;          // d1 then d0, MSB first
    bus.SE = 1'b1; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.SI = scan_pat[7-i];
      #1;
      check($sformatf("scan%0d_so", i), 32'(bus.SO), 32'(so_orig[7-i]));
      check($sformatf("scan%0d_ir", i), 32'(bus.IN_READY), 32'd0);
      check($sformatf("scan%0d_ov", i), 32'(bus.OUT_VALID), 32'd0);
      check($sformatf("scan%0d_cnt", i), 32'(bus.COUNT), 32'd2);
      step();
    end
    #1;
    check("scan_done_so", 32'(bus.SO), 32'd1);
    check("scan_done_q", 32'(bus.Q), 32'hB);

    // Leave scan: shifted data drains with the preserved valid bits.
    bus.SE = 1'b0;
    drive(1'b0, 4'h0, 1'b1); expect_out("post0", 1'b1, 4'hB, 2'd2); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("post1", 1'b1, 4'h2, 2'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("post2", 1'b0, 4'h2, 2'd0);

    // Reset while full and stalled.
    drive(1'b1, 4'h3, 1'b0); step();
    drive(1'b1, 4'h4, 1'b0); step();
    drive(1'b1, 4'h5, 1'b0); expect_out("mr_full", 1'b1, 4'h3, 2'd2);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    drive(1'b1, 4'h6, 1'b1); expect_out("mr_rst", 1'b0, 4'hA, 2'd0);
    check("mr_ir", 32'(bus.IN_READY), 32'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("mr_l1", 1'b0, 4'hA, 2'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("mr_l2", 1'b1, 4'h6, 2'd1); step();
    drive(1'b0, 4'h0, 1'b1); expect_out("mr_l3", 1'b0, 4'h6, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case the flow above ever stops advancing.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
